// File: rtl/boot_mem.sv
// Patchable boot memory: registered reads, key-sequence write unlock, and a
// background restore that reloads the power-on image one word per cycle.
module boot_mem #(
  parameter int unsigned DW                 = 16,
  parameter int unsigned AW                 = 4,
  parameter int unsigned DEPTH              = 2**AW,
  parameter logic [DEPTH*DW-1:0] INIT       = {{((DEPTH-8)*DW){1'b0}},
                                               DW'(16'h0007), DW'(16'h4000),
                                               DW'(16'h3010), DW'(16'hF400),
                                               DW'(16'h1007), DW'(16'hF800),
                                               DW'(16'h4000), DW'(16'hF200)},
  parameter logic [DW-1:0] KEY1             = DW'(16'hA5C3),
  parameter logic [DW-1:0] KEY2             = DW'(16'h3C5A),
  parameter logic [AW-1:0] KEY_ADDR         = AW'(DEPTH-1)
) (
`ifdef USE_POWER_PINS
  inout  wire           vccd1,
  inout  wire           vssd1,
`endif
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic          restore,
  input  logic          lock,
  output logic [DW-1:0] dout,
  output logic          rvalid,
  output logic          wr_err,
  output logic          busy,
  output logic          unlocked
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);
  localparam logic [DEPTH-1:0][DW-1:0] INIT_W = INIT;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_KEY1_OK  = 2'd1,
    ST_UNLOCKED = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [DEPTH-1:0][DW-1:0]  mem_q;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic [DW-1:0]             dout_q, dout_d;
  logic                      busy_q, busy_d;
  logic                      rvalid_q, rvalid_d;
  logic                      wr_err_q, wr_err_d;
  logic                      unlocked_q, unlocked_d;
  logic                      mem_we;
  logic [AW-1:0]             mem_waddr;
  logic [DW-1:0]             mem_wdata;

  logic in_range_c, key1_hit_c, key2_hit_c;
  assign in_range_c = (32'(addr) < DEPTH);
  assign key1_hit_c = (addr == KEY_ADDR) && (din == KEY1);
  assign key2_hit_c = (addr == KEY_ADDR) && (din == KEY2);

  // State register, array and output registers; reset reloads the full image.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_LOCKED;
      mem_q      <= INIT_W;
      cnt_q      <= '0;
      dout_q     <= '0;
      busy_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      unlocked_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      rvalid_q   <= rvalid_d;
      wr_err_q   <= wr_err_d;
      unlocked_q <= unlocked_d;
      if (mem_we) begin
        mem_q[mem_waddr] <= mem_wdata;
      end
    end
  end

  // Next-state: restore sweep has priority, then a new restore, then the access.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    busy_d     = busy_q;
    rvalid_d   = 1'b0;
    wr_err_d   = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = addr;
    mem_wdata  = din;

    if (busy_q) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = INIT_W[cnt_q];
      wr_err_d  = cs & we;
      if (cnt_q == LAST_ADDR) begin
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_LOCKED;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end else if (restore) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end else if (cs) begin
      if (!we) begin
        rvalid_d = 1'b1;
        dout_d   = in_range_c ? mem_q[addr] : '0;
      end else if (lock || !in_range_c) begin
        wr_err_d = 1'b1;
      end else begin
        case (state_q)
          ST_LOCKED: begin
            if (key1_hit_c) state_d = ST_KEY1_OK;
            else            wr_err_d = 1'b1;
          end
          ST_KEY1_OK: begin
            if (key2_hit_c) begin
              state_d = ST_UNLOCKED;
            end else begin
              wr_err_d = 1'b1;
              state_d  = ST_LOCKED;
            end
          end
          ST_UNLOCKED: mem_we = 1'b1;
          default:     state_d = ST_LOCKED;
        endcase
      end
    end

    if (lock) state_d = ST_LOCKED;
    unlocked_d = (state_d == ST_UNLOCKED);
  end

  assign dout     = dout_q;
  assign rvalid   = rvalid_q;
  assign wr_err   = wr_err_q;
  assign busy     = busy_q;
  assign unlocked = unlocked_q;

endmodule

// File: tb/tb_boot_mem.sv
// Directed bench for boot_mem: a 16x16 instance and a 32-bit x 32-word instance.
module tb_boot_mem;

  localparam logic [15:0] IMG [8] = '{16'hF200, 16'h4000, 16'hF800, 16'h1007,
                                      16'hF400, 16'h3010, 16'h4000, 16'h0007};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic        lock = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] din = '0;
  logic        cs_a = 1'b0, cs_b = 1'b0;
  logic        rs_a = 1'b0, rs_b = 1'b0;
  logic [15:0] dout_a;
  logic [31:0] dout_b;
  logic        rvalid_a, rvalid_b, wr_err_a, wr_err_b;
  logic        busy_a, busy_b, unl_a, unl_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  boot_mem u_a (
    .clk(clk), .rst(rst), .cs(cs_a), .we(we), .addr(addr[3:0]), .din(din[15:0]),
    .restore(rs_a), .lock(lock), .dout(dout_a), .rvalid(rvalid_a),
    .wr_err(wr_err_a), .busy(busy_a), .unlocked(unl_a)
  );

  boot_mem #(.DW(32), .AW(5)) u_b (
    .clk(clk), .rst(rst), .cs(cs_b), .we(we), .addr(addr), .din(din),
    .restore(rs_b), .lock(lock), .dout(dout_b), .rvalid(rvalid_b),
    .wr_err(wr_err_b), .busy(busy_b), .unlocked(unl_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int a);
    return (a < 8) ? {16'h0, IMG[a]} : 32'h0;
  endfunction

  function automatic logic [31:0] f_dout(input bit sel);
    return sel ? dout_b : {16'h0, dout_a};
  endfunction
  function automatic logic f_rv(input bit sel);   return sel ? rvalid_b : rvalid_a; endfunction
  function automatic logic f_err(input bit sel);  return sel ? wr_err_b : wr_err_a; endfunction
  function automatic logic f_busy(input bit sel); return sel ? busy_b : busy_a;     endfunction
  function automatic logic f_unl(input bit sel);  return sel ? unl_b : unl_a;       endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cs(input bit sel, input logic v);
    if (sel) cs_b = v; else cs_a = v;
  endtask

  task automatic rd(input bit sel, input int a, input logic [31:0] exp, input string tag);
    addr = 5'(a); we = 1'b0; set_cs(sel, 1'b1);
    tick;
    set_cs(sel, 1'b0);
    check({tag, "_rv"}, 32'(f_rv(sel)), 32'd1);
    check({tag, "_d"}, f_dout(sel), exp);
  endtask

  task automatic wr(input bit sel, input int a, input logic [31:0] d, input logic exp_err,
                    input string tag);
    addr = 5'(a); din = d; we = 1'b1; set_cs(sel, 1'b1);
    tick;
    set_cs(sel, 1'b0); we = 1'b0;
    check(tag, 32'(f_err(sel)), 32'(exp_err));
  endtask

  task automatic unlock(input bit sel);
    int ka;
    ka = sel ? 31 : 15;
    wr(sel, ka, 32'h0000A5C3, 1'b0, "key1");
    wr(sel, ka, 32'h00003C5A, 1'b0, "key2");
    check("unl_set", 32'(f_unl(sel)), 32'd1);
  endtask

  // Restore with a concurrent read, then a read and a write while busy.
  task automatic restore_run(input bit sel, input int exp_cycles);
    int n;
    int guard;
    if (sel) rs_b = 1'b1; else rs_a = 1'b1;
    addr = '0; we = 1'b0; set_cs(sel, 1'b1);
    tick;
    rs_a = 1'b0; rs_b = 1'b0;
    check("rs_cs_drop", 32'(f_rv(sel)), 32'd0);
    check("busy_rise", 32'(f_busy(sel)), 32'd1);
    n = 1;
    tick;
    set_cs(sel, 1'b0);
    if (f_busy(sel)) n++;
    check("busy_rd_drop", 32'(f_rv(sel)), 32'd0);
    we = 1'b1; din = 32'h5A5A; set_cs(sel, 1'b1);
    tick;
    set_cs(sel, 1'b0); we = 1'b0;
    if (f_busy(sel)) n++;
    check("busy_wr_err", 32'(f_err(sel)), 32'd1);
    guard = 0;
    while (f_busy(sel) && guard < 100) begin
      tick;
      guard++;
      if (f_busy(sel)) n++;
    end
    check("busy_len", 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", 32'(dout_a), 32'h0);
    check("rst_rvalid", 32'(rvalid_a), 32'h0);
    check("rst_wr_err", 32'(wr_err_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_unl", 32'(unl_a), 32'h0);
    check("rst_dout_b", dout_b, 32'h0);
    rst = 1'b1;
    tick;

    for (int i = 0; i < 9; i++) rd(1'b0, i, exp_word(i), "rd_a");

    wr(1'b0, 2, 32'h1234, 1'b1, "lk_wr");
    tick;
    check("err_pulse", 32'(wr_err_a), 32'h0);
    rd(1'b0, 2, 32'hF800, "lk_rd");

    unlock(1'b0);
    wr(1'b0, 2, 32'hBEEF, 1'b0, "patch");
    rd(1'b0, 2, 32'hBEEF, "patch_rd");
    lock = 1'b1; tick; lock = 1'b0;
    check("lock_pulse", 32'(unl_a), 32'h0);

    wr(1'b0, 15, 32'hA5C3, 1'b0, "bk1");
    wr(1'b0, 15, 32'h1111, 1'b1, "bk2");
    wr(1'b0, 15, 32'h3C5A, 1'b1, "bk3");
    check("bk_unl", 32'(unl_a), 32'h0);

    unlock(1'b0);
    lock = 1'b1;
    wr(1'b0, 2, 32'h0BAD, 1'b1, "lock_wr");
    lock = 1'b0;
    check("lock_wr_unl", 32'(unl_a), 32'h0);
    rd(1'b0, 2, 32'hBEEF, "lock_wr_rd");

    unlock(1'b0);
    wr(1'b0, 0, 32'h0, 1'b0, "p0");
    rd(1'b0, 0, 32'h0, "p0_rd");
    restore_run(1'b0, 16);
    rd(1'b0, 0, 32'hF200, "rs_rd0");
    rd(1'b0, 2, 32'hF800, "rs_rd2");
    check("rs_unl", 32'(unl_a), 32'h0);

    unlock(1'b0);
    wr(1'b0, 6, 32'h1234, 1'b0, "p6");
    rs_a = 1'b1; tick; rs_a = 1'b0;
    repeat (4) tick;
    rst = 1'b0;
    #1;
    check("midrs_busy", 32'(busy_a), 32'h0);
    check("midrs_unl", 32'(unl_a), 32'h0);
    tick;
    rst = 1'b1;
    tick;
    for (int i = 0; i < 16; i++) rd(1'b0, i, exp_word(i), "post_rst");

    for (int i = 0; i < 9; i++) rd(1'b1, i, exp_word(i), "rd_b");
    unlock(1'b1);
    wr(1'b1, 0, 32'hDEADBEEF, 1'b0, "b_p0");
    rd(1'b1, 0, 32'hDEADBEEF, "b_p0_rd");
    restore_run(1'b1, 32);
    rd(1'b1, 0, 32'hF200, "b_rs_rd0");
    check("b_rs_unl", 32'(unl_b), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/boot_mem.md
# boot_mem

Parametrised, patchable boot memory for the SoC's CPU instruction fetch path at reset vector 0. It generalises the fixed 16×16 boot ROM in three ways: width and depth are set by parameters, and reads are registered, with a valid strobe instead of a latched output. Words can also be patched after a two-word unlock sequence. A `restore` command rewrites the whole array from the parameter image over DEPTH cycles.

## Interface
Parameters:
- `DW`, 16: data width.
- `AW`, 4: address width.
- `DEPTH`, 2**AW: number of words.
- `INIT`, DEPTH*DW bits: power-on image, entry 0 in bits [DW-1:0].
  - Default image: words 0–7 = F200, 4000, F800, 1007, F400, 3010, 4000, 0007.
  - Remaining words = 0.
- `KEY1`, 16'hA5C3: first unlock word.
- `KEY2`, 16'h3C5A: second unlock word.
- `KEY_ADDR`, DEPTH-1: address at which key words are written.

Ports:
- `clk` in 1: clock. All state is updated on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `vccd1`, `vssd1` inout 1: power pins, present only under `USE_POWER_PINS`.
- `cs` in 1: access strobe.
- `we` in 1: 1 = write, 0 = read. Meaningful only with `cs`.
- `addr` in AW: word address.
- `din` in DW: write data.
- `restore` in 1: single-cycle pulse that starts an image reload.
- `lock` in 1: single-cycle pulse that forces the LOCKED state.
- `dout` out DW: registered read data.
- `rvalid` out 1: one-cycle strobe, high when `dout` holds new data.
- `wr_err` out 1: one-cycle strobe, high for a rejected write.
- `busy` out 1: high while a restore is in progress.
- `unlocked` out 1: high in the UNLOCKED state.

## Operation
Reset (`rst` low), applied immediately and independent of `clk`:
- mem[i] = INIT[i] for every i.
- `dout` = 0; `rvalid`, `wr_err`, `busy`, `unlocked` = 0.
- FSM = LOCKED; restore counter = 0.

Read (`cs` & ~`we` & ~`busy`):
- `dout` <= mem[`addr`] and `rvalid` <= 1.
- `dout` holds its value when no read is accepted.

Write (`cs` & `we` & ~`busy`), handled by the lock FSM:
- LOCKED:
  - Write of KEY1 to KEY_ADDR → KEY1_OK. The array is not written and `wr_err` stays 0.
  - Any other write is rejected: `wr_err` pulses and the state stays LOCKED.
- KEY1_OK:
  - Write of KEY2 to KEY_ADDR → UNLOCKED. The array is not written and `wr_err` stays 0.
  - Any other write is rejected: `wr_err` pulses and the state → LOCKED.
  - Reads do not change the state.
- UNLOCKED:
  - Every write performs mem[`addr`] <= `din`, including writes to KEY_ADDR.
  - The state remains UNLOCKED.
- `lock` pulse: → LOCKED from any state.
- `unlocked` = (state == UNLOCKED), driven from a register.

Restore:
- `restore` while ~`busy`: `busy` <= 1 and counter <= 0.
- Each busy cycle: mem[counter] <= INIT[counter], then counter increments.
- After the write to DEPTH-1: `busy` <= 0, counter <= 0, FSM <= LOCKED.
- `restore` while `busy` is ignored.

Simultaneous events:
- `restore` with `cs` in the same idle cycle: the restore starts and the access is dropped (no `rvalid`, no `wr_err`).
- `lock` with a write in the same cycle: `lock` wins, the write is rejected and `wr_err` pulses.
- `lock` with a read: the read is served normally.
- `cs` while `busy`:
  - Reads are dropped silently.
  - Writes are rejected with a `wr_err` pulse.
  - The FSM is unaffected.
- Addresses ≥ DEPTH (non-power-of-2 DEPTH):
  - Reads return 0 with `rvalid`.
  - Writes are rejected with a `wr_err` pulse.

## Timing
- Read latency is 1 cycle: a read accepted at edge N makes `dout` valid and `rvalid` high after edge N, for exactly one cycle.
- Back-to-back reads give one word per cycle.
- A write accepted at edge N is visible to a read accepted at edge N+1.
- The state transition for a key write takes effect after edge N. A patch write is allowed from edge N+1 onward.
- `wr_err` goes high in the cycle after the offending edge, for one cycle.
- Restore:
  - `busy` rises one cycle after `restore` is sampled.
  - `busy` stays high exactly DEPTH cycles.
  - The first access accepted after `busy` falls returns INIT contents.
- Reset asserted mid-restore or mid-unlock: all state returns to reset values at once. No partial image remains.

## Test plan
- After reset release, read addresses 0–7, one per cycle → `dout` = F200, 4000, F800, 1007, F400, 3010, 4000, 0007, each with `rvalid` one cycle after its request. Address 8 → 0000.
- Locked write of 1234 to addr 2 → `wr_err` pulse, and a read of addr 2 still returns F800.
- Unlock sequence:
  - Write A5C3 then 3C5A to addr F → `unlocked` = 1 with no `wr_err`.
  - Write BEEF to addr 2, then read addr 2 → BEEF.
  - `lock` pulse → `unlocked` = 0.
- Broken key: write A5C3 to addr F, then 1111 to addr F → `wr_err` pulse, FSM back in LOCKED. A following write of 3C5A does not unlock.
- Patch then restore:
  - Patch addr 0 = 0000, then pulse `restore` → `busy` high for 16 cycles.
  - A read issued during `busy` produces no `rvalid`.
  - After `busy` falls, a read of addr 0 returns F200 and `unlocked` = 0.
- Drive `rst` low mid-restore (cycle 5) → `busy` = 0 immediately. After release all words equal INIT.
- Run a second configuration, DW = 32, AW = 5, and repeat the read and restore scenarios.
